// File: rtl/md5_block_sched.sv
// md5_block_sched: buffers a 32-bit word stream into 16-word blocks, applies MD5 padding and length, sequences the core and chains the digest
module md5_block_sched #(
   parameter int          LEN_W = 32,
   parameter logic [31:0] IV_A  = 32'h67452301,
   parameter logic [31:0] IV_B  = 32'hefcdab89,
   parameter logic [31:0] IV_C  = 32'h98badcfe,
   parameter logic [31:0] IV_D  = 32'h10325476
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   input  logic [2:0]   in_bytes,
   output logic         core_start,
   output logic [511:0] core_block,
   output logic [31:0]  core_a,
   output logic [31:0]  core_b,
   output logic [31:0]  core_c,
   output logic [31:0]  core_d,
   input  logic         core_done,
   input  logic [31:0]  core_ra,
   input  logic [31:0]  core_rb,
   input  logic [31:0]  core_rc,
   input  logic [31:0]  core_rd,
   output logic         digest_valid,
   output logic [127:0] digest,
   output logic         busy
);
   typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, WAIT, ADD, DONE} state_t;
   state_t state, state_n;
   logic [31:0] blk [16];
   logic [4:0] wptr;
   logic [LEN_W-1:0] byte_cnt;
   logic [31:0] a, b, c, d, ra, rb, rc, rd;
   logic need_len, final_blk, pend80, accept, pad_len;
   logic [31:0] last_word;
   logic [63:0] bitlen;
   assign accept = in_valid && in_ready;
   assign in_ready = state == FILL && !wptr[4];
   // pend80: the 0x80 marker belongs in word wptr; otherwise it already sits in word wptr-1
   assign pad_len = pend80 ? wptr <= 5'd13 : wptr <= 5'd14;
   assign bitlen = 64'({byte_cnt, 3'b000});
   assign core_start = state == ISSUE;
   assign core_a = a;
   assign core_b = b;
   assign core_c = c;
   assign core_d = d;
   assign digest = {a, b, c, d};
   assign digest_valid = state == DONE;
   assign busy = state != IDLE && state != DONE;
   // the buffer is never written during ISSUE/WAIT, so it doubles as the held core block
   for (genvar g = 0; g < 16; g++) begin : g_blk
      assign core_block[32*g +: 32] = blk[g];
   end
   // final word: keep valid bytes, place the 0x80 marker right after them, clear the rest
   always_comb begin
      last_word = in_data;
      for (int k = 0; k < 4; k++)
         last_word[8*k +: 8] = 3'(k) < in_bytes ? in_data[8*k +: 8] : 3'(k) == in_bytes ? 8'h80 : 8'h00;
   end
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   // next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: state_n = start ? FILL : state;
         FILL:       state_n = !accept ? FILL : in_last ? PAD : wptr == 5'd15 ? ISSUE : FILL;
         PAD:        state_n = pad_len ? LEN : ISSUE;
         LEN:        state_n = ISSUE;
         ISSUE:      state_n = WAIT;
         WAIT:       state_n = core_done ? ADD : WAIT;
         ADD:        state_n = final_blk ? DONE : need_len ? LEN : FILL;
         default:    state_n = IDLE;
      endcase
   end
   // block buffer, counters, chaining values and padding flags
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) blk[i] <= '0;
         wptr <= '0;
         byte_cnt <= '0;
         {a, b, c, d} <= '0;
         {ra, rb, rc, rd} <= '0;
         need_len <= 1'b0;
         final_blk <= 1'b0;
         pend80 <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               {a, b, c, d} <= {IV_A, IV_B, IV_C, IV_D};
               byte_cnt <= '0;
               wptr <= '0;
               need_len <= 1'b0;
               final_blk <= 1'b0;
               pend80 <= 1'b0;
            end
            FILL: if (accept) begin
               blk[wptr[3:0]] <= in_last ? last_word : in_data;
               wptr <= wptr + 5'd1;
               byte_cnt <= byte_cnt + (in_last ? LEN_W'(in_bytes) : LEN_W'(4));
               pend80 <= in_last && in_bytes >= 3'd4;
            end
            PAD: begin
               for (int i = 0; i < 16; i++)
                  if (5'(i) >= wptr) blk[i] <= pend80 && pad_len && 5'(i) == wptr ? 32'h80 : 32'h0;
               need_len <= !pad_len;
               pend80 <= pend80 && !pad_len;
            end
            LEN: begin
               blk[14] <= bitlen[31:0];
               blk[15] <= bitlen[63:32];
               final_blk <= 1'b1;
            end
            WAIT: if (core_done) {ra, rb, rc, rd} <= {core_ra, core_rb, core_rc, core_rd};
            ADD: begin
               a <= a + ra;
               b <= b + rb;
               c <= c + rc;
               d <= d + rd;
               wptr <= '0;
               if (need_len) begin
                  for (int i = 0; i < 16; i++) blk[i] <= i == 0 && pend80 ? 32'h80 : 32'h0;
                  need_len <= 1'b0;
                  pend80 <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
